// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and small helpers for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int MAX_NUM_RD = 4;

    // Architectural zero register: never written, never pending.
    localparam int REG_ZERO = 0;

    // Low bit of port 'port' inside a flattened bus of 'width'-bit lanes.
    function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits, per-port busy lookup and a
// registered count of pending registers. A reserve on the same edge as a write
// to the same register wins, because it models a younger in-flight writer.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend_q, pend_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic             wr_hit, rsv_hit, set_new, clr_old;

    // Next pending vector and counter: clear on write, then set on reserve.
    always_comb begin
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        wr_hit  = wr_en && (wr_addr != ADDR_W'(REG_ZERO));
        rsv_hit = rsv_en && (rsv_addr != ADDR_W'(REG_ZERO));
        set_new = rsv_hit && !pend_q[rsv_addr];
        clr_old = wr_hit && pend_q[wr_addr] && !(rsv_hit && (rsv_addr == wr_addr));
        if (wr_hit) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (rsv_hit) begin
            pend_d[rsv_addr] = 1'b1;
        end
        pend_d[REG_ZERO] = 1'b0;
        case ({set_new, clr_old})
            2'b10:   cnt_d = cnt_q + (ADDR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (ADDR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pending bits and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // Per-port busy lookup.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
        assign rd_busy[i] = pend_q[rd_addr[slice_lo(i, ADDR_W) +: ADDR_W]];
    end

    assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: GPR storage with NUM_RD combinational read ports, one clocked
// write port and a pending-write scoreboard. Register 0 is hardwired to zero.
// Build option REGFILE_BYPASS_EN: forward the in-cycle write data (and a
// cleared busy) to any read port addressing the register being written.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [NUM_RD-1:0] sb_busy;
    logic              wr_hit;

    assign wr_hit = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

    // Storage array; entry 0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (wr_hit) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (sb_busy),
        .pend_cnt (pend_cnt)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign addr = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];

        // Read mux for port i, with optional same-cycle write forwarding.
        always_comb begin
            data = mem_q[addr];
            busy = sb_busy[i];
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && (addr == wr_addr)) begin
                data = wr_data;
                if (!(rsv_en && (rsv_addr == wr_addr))) begin
                    busy = 1'b0;
                end
            end
`endif
        end

        assign rd_data[slice_lo(i, DATA_W) +: DATA_W] = data;
        assign rd_busy[i] = busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed stimulus on two register-file instances (default
// 32x32 with two ports, and 8-entry with four ports), an array-based reference
// model checked every negative clock edge, and literal spot checks.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // ---------------- instance A: DATA_W=32, ADDR_W=5, NUM_RD=2
    logic [9:0]  a_rd_addr = '0;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wr_en = 1'b0;
    logic [4:0]  a_wr_addr = '0;
    logic [31:0] a_wr_data = '0;
    logic        a_rsv_en = 1'b0;
    logic [4:0]  a_rsv_addr = '0;
    logic [5:0]  a_pend_cnt;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .pend_cnt(a_pend_cnt)
    );

    // ---------------- instance B: DATA_W=32, ADDR_W=3, NUM_RD=4
    logic [11:0]  b_rd_addr = '0;
    logic [127:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic         b_wr_en = 1'b0;
    logic [2:0]   b_wr_addr = '0;
    logic [31:0]  b_wr_data = '0;
    logic         b_rsv_en = 1'b0;
    logic [2:0]   b_rsv_addr = '0;
    logic [3:0]   b_pend_cnt;

    regfile_mp #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .pend_cnt(b_pend_cnt)
    );

    // ---------------- reference model: plain arrays of values and pending flags
    logic [31:0] ma_mem [32];
    bit          ma_pend [32];
    logic [31:0] mb_mem [8];
    bit          mb_pend [8];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) begin ma_mem[k] <= '0; ma_pend[k] <= 1'b0; end
            for (int k = 0; k < 8; k++)  begin mb_mem[k] <= '0; mb_pend[k] <= 1'b0; end
        end else begin
            // write first, reserve afterwards so a same-register reserve wins
            if (a_wr_en && a_wr_addr != 0) begin
                ma_mem[a_wr_addr]  <= a_wr_data;
                ma_pend[a_wr_addr] <= 1'b0;
            end
            if (a_rsv_en && a_rsv_addr != 0) ma_pend[a_rsv_addr] <= 1'b1;
            if (b_wr_en && b_wr_addr != 0) begin
                mb_mem[b_wr_addr]  <= b_wr_data;
                mb_pend[b_wr_addr] <= 1'b0;
            end
            if (b_rsv_en && b_rsv_addr != 0) mb_pend[b_rsv_addr] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process (every negative edge once enabled)
    int          ca_addr, cb_addr, ca_cnt, cb_cnt;
    logic [31:0] ca_data, cb_data;
    bit          ca_busy, cb_busy;

    always @(negedge clk) begin
        if (chk_en) begin
            ca_cnt = 0;
            for (int k = 0; k < 32; k++) ca_cnt += int'(ma_pend[k]);
            for (int i = 0; i < 2; i++) begin
                ca_addr = int'(a_rd_addr[i*5 +: 5]);
                ca_data = ma_mem[ca_addr];
                ca_busy = ma_pend[ca_addr];
`ifdef REGFILE_BYPASS_EN
                if (a_wr_en && a_wr_addr != 0 && ca_addr == int'(a_wr_addr)) begin
                    ca_data = a_wr_data;
                    if (!(a_rsv_en && a_rsv_addr == a_wr_addr)) ca_busy = 1'b0;
                end
`endif
                chk($sformatf("a_rd_data[%0d]", i), 64'(a_rd_data[i*32 +: 32]), 64'(ca_data));
                chk($sformatf("a_rd_busy[%0d]", i), 64'(a_rd_busy[i]), 64'(ca_busy));
            end
            chk("a_pend_cnt", 64'(a_pend_cnt), 64'(ca_cnt));

            cb_cnt = 0;
            for (int k = 0; k < 8; k++) cb_cnt += int'(mb_pend[k]);
            for (int i = 0; i < 4; i++) begin
                cb_addr = int'(b_rd_addr[i*3 +: 3]);
                cb_data = mb_mem[cb_addr];
                cb_busy = mb_pend[cb_addr];
`ifdef REGFILE_BYPASS_EN
                if (b_wr_en && b_wr_addr != 0 && cb_addr == int'(b_wr_addr)) begin
                    cb_data = b_wr_data;
                    if (!(b_rsv_en && b_rsv_addr == b_wr_addr)) cb_busy = 1'b0;
                end
`endif
                chk($sformatf("b_rd_data[%0d]", i), 64'(b_rd_data[i*32 +: 32]), 64'(cb_data));
                chk($sformatf("b_rd_busy[%0d]", i), 64'(b_rd_busy[i]), 64'(cb_busy));
            end
            chk("b_pend_cnt", 64'(b_pend_cnt), 64'(cb_cnt));
        end
    end

    // ---------------- stimulus helpers: drive 1 time unit after the rising edge
    task automatic drv_a(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra,
                         input logic [4:0] r0, input logic [4:0] r1);
        @(posedge clk);
        #1;
        a_wr_en = we; a_wr_addr = wa; a_wr_data = wd;
        a_rsv_en = re; a_rsv_addr = ra;
        a_rd_addr = {r1, r0};
    endtask

    task automatic drv_b(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                         input logic re, input logic [2:0] ra, input logic [11:0] rds);
        @(posedge clk);
        #1;
        b_wr_en = we; b_wr_addr = wa; b_wr_data = wd;
        b_rsv_en = re; b_rsv_addr = ra;
        b_rd_addr = rds;
    endtask

    function automatic logic [31:0] a_port(input int i);
        return a_rd_data[i*32 +: 32];
    endfunction

    // ---------------- directed sequence with literal expectations
    initial begin
        #2;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("lit reset pend_cnt", 64'(a_pend_cnt), 64'd0);
        rst_n = 1'b1;

        // write r3=4, read ports (2,3)
        drv_a(1, 5'd3, 32'h4, 0, 0, 5'd2, 5'd3);
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        chk("lit r3 write cycle", 64'(a_port(1)), 64'h4);
`else
        chk("lit r3 write cycle", 64'(a_port(1)), 64'h0);
`endif
        drv_a(0, 0, 0, 0, 0, 5'd2, 5'd3);
        @(negedge clk);
        chk("lit r3 next cycle", 64'(a_port(1)), 64'h4);
        chk("lit r2 zero", 64'(a_port(0)), 64'h0);

        // write to r0 has no effect
        drv_a(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 5'd0, 5'd3);
        @(negedge clk);
        chk("lit r0 write cycle", 64'(a_port(0)), 64'h0);
        drv_a(0, 0, 0, 0, 0, 5'd0, 5'd3);
        @(negedge clk);
        chk("lit r0 after write", 64'(a_port(0)), 64'h0);

        // reserve r6 then r7
        drv_a(0, 0, 0, 1, 5'd6, 5'd0, 5'd0);
        drv_a(0, 0, 0, 1, 5'd7, 5'd6, 5'd7);
        @(negedge clk);
        chk("lit r6 busy, r7 not yet", 64'(a_rd_busy), 64'b01);
        drv_a(0, 0, 0, 0, 0, 5'd6, 5'd7);
        @(negedge clk);
        chk("lit pend_cnt 2", 64'(a_pend_cnt), 64'd2);
        chk("lit r6 r7 busy", 64'(a_rd_busy), 64'b11);

        // write r6 clears its pending bit
        drv_a(1, 5'd6, 32'h4, 0, 0, 5'd6, 5'd7);
        @(negedge clk);
        chk("lit pend_cnt before clear", 64'(a_pend_cnt), 64'd2);
        drv_a(0, 0, 0, 0, 0, 5'd6, 5'd7);
        @(negedge clk);
        chk("lit pend_cnt 1", 64'(a_pend_cnt), 64'd1);
        chk("lit r6 free r7 busy", 64'(a_rd_busy), 64'b10);
        chk("lit r6 reads 4", 64'(a_port(0)), 64'h4);

        // same-register write and reserve while pending
        drv_a(0, 0, 0, 1, 5'd5, 5'd5, 5'd5);
        drv_a(1, 5'd5, 32'hA, 1, 5'd5, 5'd5, 5'd5);
        @(negedge clk);
        chk("lit collision busy", 64'(a_rd_busy), 64'b11);
        drv_a(0, 0, 0, 0, 0, 5'd5, 5'd5);
        @(negedge clk);
        chk("lit collision data", 64'(a_port(0)), 64'hA);
        chk("lit collision busy after", 64'(a_rd_busy), 64'b11);
        chk("lit collision pend_cnt", 64'(a_pend_cnt), 64'd2);

        // bypass behaviour on r9
        drv_a(1, 5'd9, 32'h55, 0, 0, 5'd0, 5'd0);
        drv_a(0, 0, 0, 1, 5'd9, 5'd9, 5'd9);
        drv_a(1, 5'd9, 32'h1234, 0, 0, 5'd9, 5'd9);
        @(negedge clk);
        chk("lit r9 pend_cnt 3", 64'(a_pend_cnt), 64'd3);
`ifdef REGFILE_BYPASS_EN
        chk("lit r9 bypass data", 64'(a_port(0)), 64'h1234);
        chk("lit r9 bypass busy", 64'(a_rd_busy), 64'b00);
`else
        chk("lit r9 old data", 64'(a_port(0)), 64'h55);
        chk("lit r9 still busy", 64'(a_rd_busy), 64'b11);
`endif
        drv_a(0, 0, 0, 0, 0, 5'd9, 5'd9);
        @(negedge clk);
        chk("lit r9 new data", 64'(a_port(1)), 64'h1234);
        chk("lit r9 pend_cnt 2", 64'(a_pend_cnt), 64'd2);

        // write to a non-pending register leaves the count alone
        drv_a(1, 5'd10, 32'hBEEF, 0, 0, 5'd10, 5'd5);
        drv_a(0, 0, 0, 0, 0, 5'd10, 5'd5);
        @(negedge clk);
        chk("lit r10 data", 64'(a_port(0)), 64'hBEEF);
        chk("lit r10 pend_cnt", 64'(a_pend_cnt), 64'd2);

        // write r5 and reserve r11 on the same edge: net zero
        drv_a(1, 5'd5, 32'h77, 1, 5'd11, 5'd5, 5'd11);
        drv_a(0, 0, 0, 0, 0, 5'd5, 5'd11);
        @(negedge clk);
        chk("lit swap pend_cnt", 64'(a_pend_cnt), 64'd2);
        chk("lit swap busy", 64'(a_rd_busy), 64'b10);
        chk("lit r5 new data", 64'(a_port(0)), 64'h77);

        // asynchronous reset mid-operation
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("lit async rst data", 64'(a_rd_data), 64'h0);
        chk("lit async rst busy", 64'(a_rd_busy), 64'b00);
        chk("lit async rst pend", 64'(a_pend_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drv_a(0, 0, 0, 0, 0, 5'd3, 5'd6);
        @(negedge clk);
        chk("lit r3 r6 discarded", 64'(a_rd_data), 64'h0);

        // instance B: reserve every register r1..r7
        for (int k = 1; k < 8; k++) drv_b(0, 0, 0, 1, 3'(k), 12'h000);
        drv_b(0, 0, 0, 1, 3'd1, 12'h000);
        @(negedge clk);
        chk("lit b pend_cnt 7", 64'(b_pend_cnt), 64'd7);
        drv_b(0, 0, 0, 0, 0, {3'd7, 3'd3, 3'd2, 3'd1});
        @(negedge clk);
        chk("lit b re-reserve stays 7", 64'(b_pend_cnt), 64'd7);
        chk("lit b all busy", 64'(b_rd_busy), 64'hF);
        drv_b(0, 0, 0, 0, 0, 12'h000);
        @(negedge clk);
        chk("lit b r0 data", 64'(b_rd_data), 64'h0);
        chk("lit b r0 busy", 64'(b_rd_busy), 64'h0);
        drv_b(1, 3'd3, 32'h33, 0, 0, {3'd0, 3'd3, 3'd3, 3'd3});
        drv_b(0, 0, 0, 0, 0, {3'd0, 3'd3, 3'd3, 3'd3});
        @(negedge clk);
        chk("lit b pend_cnt 6", 64'(b_pend_cnt), 64'd6);
        chk("lit b r3 data", 64'(b_rd_data[95:64]), 64'h33);
        chk("lit b r3 busy", 64'(b_rd_busy), 64'h0);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with a per-register pending-write scoreboard, the next generation of the single-cycle datapath's two-read/one-write register file. It holds the architectural GPRs, accepts one clocked write per cycle, serves NUM_RD combinational reads, and tracks which destinations have an in-flight writer so the pipeline's hazard logic can stall on busy sources. Register 0 is hardwired to zero.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port i source has a pending writer
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write destination
- wr_data  in  DATA_W  write value
- rsv_en  in  1  reserve strobe: mark rsv_addr pending
- rsv_addr  in  ADDR_W  destination being reserved
- pend_cnt  out  ADDR_W+1  number of registers currently pending (registered)

## Operation
- Storage: 2**ADDR_W words of DATA_W; entry 0 never written, always reads 0, never pending.
- Write: on rising clk with wr_en=1 and wr_addr!=0, mem[wr_addr] <= wr_data; pending[wr_addr] cleared.
- Read: rd_data[i] = mem[rd_addr[i]] combinationally; rd_busy[i] = pending[rd_addr[i]].
- Reserve: on rising clk with rsv_en=1 and rsv_addr!=0, pending[rsv_addr] <= 1.
- Simultaneous write and reserve, same address: reserve wins (pending stays 1, data written) — models a younger writer to the same destination.
- Reserve of an already-pending register: no change.
- Write to a non-pending register: data written, pending unchanged (0).
- pend_cnt: +1 when reserve sets a previously clear bit; -1 when write clears a set bit; both on different addresses -> net 0; same-address case -> unchanged. Never wraps: max value 2**ADDR_W-1.
- All read ports independent; any number may alias the same address.

## Timing
- Reset (rst_n=0, asynchronous): all entries 0, all pending 0, pend_cnt 0; hence rd_data all 0, rd_busy all 0. Deassertion takes effect at the next rising clk.
- Write latency: data visible on rd_data the cycle after the write edge (bypass disabled), or same cycle (bypass enabled).
- Reserve latency: rd_busy rises the cycle after the reserve edge.
- Reset mid-operation discards all pending state; no partial writes.

## Configuration
- REGFILE_BYPASS_EN defined: when wr_en=1, wr_addr!=0 and rd_addr[i]==wr_addr, rd_data[i]=wr_data and rd_busy[i]=0 in the same cycle, unless rsv_en=1 with rsv_addr==wr_addr (busy then stays as stored). Port 0 to address 0 still reads 0.
- Undefined: reads return stored contents only; write visible one cycle later.

## Structure
- Package regfile_pkg: default DATA_W/ADDR_W/NUM_RD constants, REG_ZERO address constant, port-slice helper functions.
- Sub-module regfile_scoreboard: pending bit vector, rd_busy lookup and pend_cnt counter; top holds storage array and read/bypass muxing.

## Test plan
- Reset: assert rst_n=0 mid-run after writes -> all rd_data=0, rd_busy=0, pend_cnt=0 immediately.
- Basic write/read: write 32'h4 to r3, read ports (2,3) -> next cycle rd_data = {r3=4, r2=0}; write 32'hFFFF_FFFF to r0 -> r0 reads 0.
- Scoreboard: reserve r6, r7 -> pend_cnt=2, rd_busy on r6 port=1; write r6=32'h4 -> pend_cnt=1, r6 busy=0, reads 4.
- Same-address collision: reserve r5 and write r5=32'hA same edge while r5 pending -> r5 reads A, busy stays 1, pend_cnt unchanged.
- Bypass (REGFILE_BYPASS_EN): read r9 while writing r9=32'h1234 -> rd_data=1234 and rd_busy=0 same cycle; without macro -> old value until next cycle.
- NUM_RD=4, ADDR_W=3: reserve all r1..r7 -> pend_cnt=7, re-reserve r1 -> stays 7; all four ports reading r0 -> all 0, not busy.
